// File: rtl/wb_regfile_pkg.sv
// Shared RV32I definitions for the write-back stage and the register file.
package riscv_defs;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_SP   = 5'd2;
    localparam reg_addr_t REG_GP   = 5'd3;

    localparam logic WB_SEL_ALU = 1'b0;
    localparam logic WB_SEL_MEM = 1'b1;
endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB, ID-read and debug signals of wb_regfile; WB_TRACE_EN adds the trace outputs.
interface wb_regfile_if
    import riscv_defs::*;
#(
    parameter int XLEN = riscv_defs::XLEN
);
    logic            wb_aluOut_WB_memOut;
    logic            wb_writeReg;
    logic [XLEN-1:0] wb_outMem;
    logic [XLEN-1:0] wb_outAlu;
    reg_addr_t       wb_rd;
    reg_addr_t       id_rs1;
    reg_addr_t       id_rs2;
    logic [XLEN-1:0] id_rdata1;
    logic [XLEN-1:0] id_rdata2;
    logic [XLEN-1:0] wb_data;
    reg_addr_t       dbg_addr;
    logic [XLEN-1:0] dbg_data;
`ifdef WB_TRACE_EN
    logic            trace_valid;
    reg_addr_t       trace_rd;
    logic [XLEN-1:0] trace_data;
    logic [31:0]     retire_cnt;

    modport master (
        output wb_aluOut_WB_memOut, wb_writeReg, wb_outMem, wb_outAlu, wb_rd,
               id_rs1, id_rs2, dbg_addr,
        input  id_rdata1, id_rdata2, wb_data, dbg_data,
               trace_valid, trace_rd, trace_data, retire_cnt
    );
    modport slave (
        input  wb_aluOut_WB_memOut, wb_writeReg, wb_outMem, wb_outAlu, wb_rd,
               id_rs1, id_rs2, dbg_addr,
        output id_rdata1, id_rdata2, wb_data, dbg_data,
               trace_valid, trace_rd, trace_data, retire_cnt
    );
`else
    modport master (
        output wb_aluOut_WB_memOut, wb_writeReg, wb_outMem, wb_outAlu, wb_rd,
               id_rs1, id_rs2, dbg_addr,
        input  id_rdata1, id_rdata2, wb_data, dbg_data
    );
    modport slave (
        input  wb_aluOut_WB_memOut, wb_writeReg, wb_outMem, wb_outAlu, wb_rd,
               id_rs1, id_rs2, dbg_addr,
        output id_rdata1, id_rdata2, wb_data, dbg_data
    );
`endif
endinterface

// File: rtl/wb_regfile_read_port.sv
// One combinational source-operand port: x0 forces zero, a matching WB write wins over storage.
module regfile_read_port
    import riscv_defs::*;
#(
    parameter int XLEN = riscv_defs::XLEN
) (
    input  reg_addr_t       rs,
    input  logic            wr_en,
    input  reg_addr_t       wr_rd,
    input  logic [XLEN-1:0] wr_data,
    input  logic [XLEN-1:0] rf_data,
    output logic [XLEN-1:0] rdata
);
    always_comb begin
        rdata = rf_data;
        if (rs == REG_ZERO)
            rdata = '0;
        else if (wr_en && wr_rd == rs)
            rdata = wr_data;
    end
endmodule

// File: rtl/wb_regfile.sv
// Write-back select plus x0..x31 register file with bypassed ID reads and a registered debug port.
// Optional trace/retire outputs are built when WB_TRACE_EN is defined.
module wb_regfile
    import riscv_defs::*;
#(
    parameter int               XLEN    = riscv_defs::XLEN,
    parameter logic [XLEN-1:0]  SP_INIT = 32'h0000_1000,
    parameter logic [XLEN-1:0]  GP_INIT = 32'h0000_0800
) (
    input logic         clk,
    input logic         rst,
    wb_regfile_if.slave bus
);
    localparam int NUM_RD = 2;

    logic [XLEN-1:0] rf [NUM_REGS];
    logic            commit;
    reg_addr_t       rs    [NUM_RD];
    logic [XLEN-1:0] rdata [NUM_RD];

    assign bus.wb_data = (bus.wb_aluOut_WB_memOut == WB_SEL_MEM) ? bus.wb_outMem : bus.wb_outAlu;
    assign commit      = bus.wb_writeReg && (bus.wb_rd != REG_ZERO);

    // rf[0] is only ever reset to zero, so every read of index 0 naturally yields 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                rf[i] <= '0;
            rf[REG_SP]   <= SP_INIT;
            rf[REG_GP]   <= GP_INIT;
            bus.dbg_data <= '0;
        end else begin
            if (commit)
                rf[bus.wb_rd] <= bus.wb_data;
            bus.dbg_data <= rf[bus.dbg_addr];
        end
    end

    assign rs[0] = bus.id_rs1;
    assign rs[1] = bus.id_rs2;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rp
        regfile_read_port #(.XLEN(XLEN)) u_rp (
            .rs      (rs[p]),
            .wr_en   (bus.wb_writeReg),
            .wr_rd   (bus.wb_rd),
            .wr_data (bus.wb_data),
            .rf_data (rf[rs[p]]),
            .rdata   (rdata[p])
        );
    end

    assign bus.id_rdata1 = rdata[0];
    assign bus.id_rdata2 = rdata[1];

`ifdef WB_TRACE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.trace_valid <= 1'b0;
            bus.trace_rd    <= '0;
            bus.trace_data  <= '0;
            bus.retire_cnt  <= '0;
        end else begin
            bus.trace_valid <= commit;
            if (commit) begin
                bus.trace_rd   <= bus.wb_rd;
                bus.trace_data <= bus.wb_data;
                bus.retire_cnt <= bus.retire_cnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_wb_regfile.sv
// Random + directed scoreboard bench for wb_regfile against an array model of x0..x31.
`timescale 1ns/1ps
module tb_wb_regfile;
    import riscv_defs::*;

    localparam logic [31:0] SP0 = 32'h0000_1000;
    localparam logic [31:0] GP0 = 32'h0000_0800;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_regfile_if #(.XLEN(32)) bus ();

    wb_regfile #(.XLEN(32), .SP_INIT(SP0), .GP_INIT(GP0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef enum {K_WB, K_RD1, K_RD2, K_DBG, K_TV, K_TRD, K_TDATA, K_RCNT} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: every negedge drains whatever the stimulus queued for this cycle
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_WB:    act = bus.wb_data;
                K_RD1:   act = bus.id_rdata1;
                K_RD2:   act = bus.id_rdata2;
                K_DBG:   act = bus.dbg_data;
`ifdef WB_TRACE_EN
                K_TV:    act = {31'd0, bus.trace_valid};
                K_TRD:   act = {27'd0, bus.trace_rd};
                K_TDATA: act = bus.trace_data;
                K_RCNT:  act = bus.retire_cnt;
`endif
                default: act = 32'hxxxx_xxxx;
            endcase
            n_checks++;
            if (act !== e.exp) begin
                n_fail++;
                $display("FAIL %s at %0t: got %h, expected %h", e.kind.name(), $time, act, e.exp);
            end
        end
    end

    // Immediate directed check, used for async-reset state
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Watchdog: the run must finish well before this wait expires
    initial begin
        #100000;
        n_fail++;
        $display("FAIL timeout at %0t: test did not complete", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Reference model
    logic [31:0] m [32];
    logic [31:0] retire;
    bit          pend_v;
    logic [31:0] pend_dbg;
    bit          pt_v;
    logic        pt_valid;
    logic [4:0]  pt_rd;
    logic [31:0] pt_data;

    function automatic void push(kind_t k, logic [31:0] v);
        exp_t e;
        e.kind = k;
        e.exp  = v;
        sb.push_back(e);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m[i] = 32'd0;
        m[2]   = SP0;
        m[3]   = GP0;
        retire = 32'd0;
    endfunction

    function automatic logic [31:0] rd_exp(logic [4:0] rs, logic we, logic [4:0] rd, logic [31:0] wd);
        if (rs == 5'd0) return 32'd0;
        if (we && rd == rs) return wd;
        return m[rs];
    endfunction

    // Called at posedge+1; drives one cycle and queues its expectations, returns at next posedge+1
    task automatic step(input logic sel, input logic we, input logic [31:0] mem, input logic [31:0] alu,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] dbg);
        logic [31:0] wd;
        if (pend_v) push(K_DBG, pend_dbg);
`ifdef WB_TRACE_EN
        if (pt_v) begin
            push(K_TV, {31'd0, pt_valid});
            if (pt_valid) begin
                push(K_TRD, {27'd0, pt_rd});
                push(K_TDATA, pt_data);
            end
            push(K_RCNT, retire);
        end
`endif
        bus.wb_aluOut_WB_memOut = sel;
        bus.wb_writeReg         = we;
        bus.wb_outMem           = mem;
        bus.wb_outAlu           = alu;
        bus.wb_rd               = rd;
        bus.id_rs1              = rs1;
        bus.id_rs2              = rs2;
        bus.dbg_addr            = dbg;
        wd = sel ? mem : alu;
        push(K_WB, wd);
        push(K_RD1, rd_exp(rs1, we, rd, wd));
        push(K_RD2, rd_exp(rs2, we, rd, wd));
        pend_v   = 1'b1;
        pend_dbg = rst ? m[dbg] : 32'd0;
        @(posedge clk);
        if (rst && we && rd != 5'd0) begin
            m[rd]    = wd;
            retire   = retire + 32'd1;
            pt_valid = 1'b1;
            pt_rd    = rd;
            pt_data  = wd;
        end else begin
            pt_valid = 1'b0;
        end
        pt_v = 1'b1;
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        model_reset();
        pend_v   = 1'b1;
        pend_dbg = 32'd0;
        pt_v     = 1'b1;
        pt_valid = 1'b0;
    endtask

    initial begin
        logic       sel, we;
        logic [4:0] rd, rs1, rs2, dbg;
        rst = 1'b1;
        bus.wb_aluOut_WB_memOut = 1'b0;
        bus.wb_writeReg = 1'b0;
        bus.wb_outMem = '0;
        bus.wb_outAlu = '0;
        bus.wb_rd = '0;
        bus.id_rs1 = '0;
        bus.id_rs2 = '0;
        bus.dbg_addr = '0;
        pend_v = 1'b0;
        pt_v = 1'b0;
        pt_valid = 1'b0;
        pt_rd = '0;
        pt_data = '0;
        pend_dbg = '0;
        model_reset();
        #1;
        apply_reset();
        @(posedge clk);
        #1;
        // Writes while held in reset must not land
        step(0, 1, 32'h0, 32'h1111_1111, 5'd5, 5'd2, 5'd3, 5'd5);
        step(1, 1, 32'h2222_2222, 32'h0, 5'd6, 5'd5, 5'd6, 5'd2);
        rst = 1'b1;
        step(0, 0, 32'h0, 32'h0, 5'd0, 5'd2, 5'd3, 5'd2);
        step(0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd6, 5'd3);
        step(0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd5);
        // ALU write, then read back
        step(0, 1, 32'h0, 32'hDEAD_BEEF, 5'd5, 5'd1, 5'd4, 5'd5);
        step(0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0, 5'd5);
        // Memory select
        step(1, 1, 32'h1234_5678, 32'hFFFF_FFFF, 5'd7, 5'd0, 5'd7, 5'd7);
        step(0, 0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7, 5'd7);
        // Same-cycle bypass on both ports, debug shows pre-write value first
        step(0, 1, 32'h0, 32'hA5A5_A5A5, 5'd9, 5'd9, 5'd9, 5'd9);
        step(0, 0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0, 5'd9);
        // x0 protection
        step(0, 1, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 5'd0);
        step(0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd9, 5'd0);
        // Asynchronous reset between edges
        step(0, 1, 32'h0, 32'h0000_0055, 5'd5, 5'd5, 5'd2, 5'd5);
        step(0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd2, 5'd5);
        apply_reset();
        #1;
        chk("RST_X5", bus.id_rdata1, 32'd0);
        chk("RST_X2", bus.id_rdata2, SP0);
        chk("RST_DBG", bus.dbg_data, 32'd0);
`ifdef WB_TRACE_EN
        chk("RST_RCNT", bus.retire_cnt, 32'd0);
        chk("RST_TV", {31'd0, bus.trace_valid}, 32'd0);
`endif
        step(0, 1, 32'h0, 32'h7777_7777, 5'd5, 5'd5, 5'd2, 5'd5);
        rst = 1'b1;
        step(0, 0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd2, 5'd2);
        // Randomized traffic biased toward low indices so reads hit recent writes
        for (int i = 0; i < 400; i++) begin
            sel = 1'($urandom_range(0, 1));
            we  = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            rs1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 7));
            dbg = ($urandom_range(0, 1) != 0) ? rd : 5'($urandom_range(0, 31));
            if (i == 200) apply_reset();
            if (i == 202) rst = 1'b1;
            step(sel, we, $urandom, $urandom, rd, rs1, rs2, dbg);
        end
        step(0, 0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 5'd0);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
